day_of_year_calc: RTL and testbench

- Converts a calendar date (day of month, month, year) into the ordinal day of the year, 1..366.
- Registered, single-cycle-latency datapath block, used by date/time-keeping logic that needs a linear day index.
- Calendar rule (Gregorian or Julian) is selected by a parameter.
- Invalid dates are flagged and produce a zero result.

---
 rtl/day_of_year_calc.sv | 116 +++++++++++
 tb/tb_day_of_year_calc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/day_of_year_calc.sv
// Calendar date to ordinal day-of-year (1..366) with one-cycle registered latency.
// Optional registered leap flag output enabled by defining DAYOFYR_LEAP_FLAG_EN.
module day_of_year_calc #(
  parameter int CALENDER = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  dayOfMonth,
  input  logic [3:0]  month,
  input  logic [10:0] year,
  output logic [8:0]  dayOfYear,
  output logic        valid
`ifdef DAYOFYR_LEAP_FLAG_EN
  ,
  output logic        isLeap
`endif
);

  localparam int unsigned DOY_W  = 9;
  localparam int unsigned DAY_W  = 6;
  localparam int unsigned YEAR_W = 11;
  localparam bit          JULIAN = (CALENDER == 1);

  logic             div4_c;
  logic             div100_c;
  logic             div400_c;
  logic             leap_c;
  logic [DOY_W-1:0] cum_c;
  logic [DAY_W-1:0] mlen_c;
  logic             month_ok_c;
  logic             date_ok_c;

  logic [DOY_W-1:0] doy_d, doy_q;
  logic             valid_d, valid_q;

  // 100 = 4*25 and 400 = 16*25, so only one true constant modulo is needed.
  assign div4_c   = (year[1:0] == 2'b00);
  assign div100_c = div4_c && ((year % YEAR_W'(25)) == YEAR_W'(0));
  assign div400_c = div100_c && (year[3:2] == 2'b00);
  assign leap_c   = JULIAN ? div4_c : (div4_c && (!div100_c || div400_c));

  // Days preceding the month, leap day folded in from March onward.
  always_comb begin
    cum_c = '0;
    unique case (month)
      4'd1:    cum_c = DOY_W'(0);
      4'd2:    cum_c = DOY_W'(31);
      4'd3:    cum_c = DOY_W'(59);
      4'd4:    cum_c = DOY_W'(90);
      4'd5:    cum_c = DOY_W'(120);
      4'd6:    cum_c = DOY_W'(151);
      4'd7:    cum_c = DOY_W'(181);
      4'd8:    cum_c = DOY_W'(212);
      4'd9:    cum_c = DOY_W'(243);
      4'd10:   cum_c = DOY_W'(273);
      4'd11:   cum_c = DOY_W'(304);
      4'd12:   cum_c = DOY_W'(334);
      default: cum_c = '0;
    endcase
    if (leap_c && (month >= 4'd3)) begin
      cum_c = cum_c + DOY_W'(1);
    end
  end

  always_comb begin
    mlen_c = '0;
    unique case (month)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: mlen_c = DAY_W'(31);
      4'd4, 4'd6, 4'd9, 4'd11:                    mlen_c = DAY_W'(30);
      4'd2:    mlen_c = leap_c ? DAY_W'(29) : DAY_W'(28);
      default: mlen_c = '0;
    endcase
  end

  assign month_ok_c = (month >= 4'd1) && (month <= 4'd12);
  assign date_ok_c  = month_ok_c && (dayOfMonth != '0) && (dayOfMonth <= mlen_c);

  always_comb begin
    doy_d   = '0;
    valid_d = date_ok_c;
    if (date_ok_c) begin
      doy_d = cum_c + DOY_W'(dayOfMonth);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      doy_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      doy_q   <= doy_d;
      valid_q <= valid_d;
    end
  end

  assign dayOfYear = doy_q;
  assign valid     = valid_q;

`ifdef DAYOFYR_LEAP_FLAG_EN
  logic leap_d, leap_q;

  // Reflects the sampled year even when the date itself is illegal.
  assign leap_d = leap_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leap_q <= 1'b0;
    end else begin
      leap_q <= leap_d;
    end
  end

  assign isLeap = leap_q;
`endif

endmodule

// File: tb/tb_day_of_year_calc.sv
// Bench for day_of_year_calc: Gregorian and Julian instances driven in parallel,
// directed plan cases plus random dates against an arithmetic calendar model.
module tb_day_of_year_calc;

  logic        clk;
  logic        rst;
  logic [5:0]  dayOfMonth;
  logic [3:0]  month;
  logic [10:0] year;
  logic [8:0]  doy_g, doy_j;
  logic        valid_g, valid_j;
`ifdef DAYOFYR_LEAP_FLAG_EN
  logic        leap_g, leap_j;
`endif

  int checks = 0;
  int errors = 0;

  day_of_year_calc #(.CALENDER(0)) dut_g (
    .clk        (clk),
    .rst        (rst),
    .dayOfMonth (dayOfMonth),
    .month      (month),
    .year       (year),
    .dayOfYear  (doy_g),
    .valid      (valid_g)
`ifdef DAYOFYR_LEAP_FLAG_EN
    ,
    .isLeap     (leap_g)
`endif
  );

  day_of_year_calc #(.CALENDER(1)) dut_j (
    .clk        (clk),
    .rst        (rst),
    .dayOfMonth (dayOfMonth),
    .month      (month),
    .year       (year),
    .dayOfYear  (doy_j),
    .valid      (valid_j)
`ifdef DAYOFYR_LEAP_FLAG_EN
    ,
    .isLeap     (leap_j)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_leap(int y, int cal);
    if (cal == 1) return (y % 4) == 0;
    return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
  endfunction

  function automatic int m_doy(int d, int m, int y, int cal);
    int lens [12];
    int total;
    lens = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m_leap(y, cal)) lens[1] = 29;
    if (m < 1 || m > 12) return 0;
    if (d < 1 || d > lens[m-1]) return 0;
    total = d;
    for (int i = 0; i < m - 1; i++) total += lens[i];
    return total;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply a date, clock it in, then check both calendars against the model.
  task automatic apply(input int d, input int m, input int y);
    int eg, ej;
    dayOfMonth = 6'(d);
    month      = 4'(m);
    year       = 11'(y);
    @(posedge clk);
    #1;
    eg = m_doy(d, m, y, 0);
    ej = m_doy(d, m, y, 1);
    chk($sformatf("greg_doy %0d/%0d/%0d", m, d, y), 32'(doy_g), 32'(eg));
    chk($sformatf("greg_valid %0d/%0d/%0d", m, d, y), 32'(valid_g), 32'(eg != 0));
    chk($sformatf("jul_doy %0d/%0d/%0d", m, d, y), 32'(doy_j), 32'(ej));
    chk($sformatf("jul_valid %0d/%0d/%0d", m, d, y), 32'(valid_j), 32'(ej != 0));
`ifdef DAYOFYR_LEAP_FLAG_EN
    chk($sformatf("greg_leap %0d", y), 32'(leap_g), 32'(m_leap(y, 0)));
    chk($sformatf("jul_leap %0d", y), 32'(leap_j), 32'(m_leap(y, 1)));
`endif
  endtask

  // Directed case with a hand-written Gregorian expectation.
  task automatic directed(input int d, input int m, input int y, input int exp_g);
    apply(d, m, y);
    chk($sformatf("plan_greg %0d/%0d/%0d", m, d, y), 32'(doy_g), 32'(exp_g));
    chk($sformatf("plan_greg_valid %0d/%0d/%0d", m, d, y), 32'(valid_g), 32'(exp_g != 0));
  endtask

  initial begin
    rst        = 1'b1;
    dayOfMonth = '0;
    month      = '0;
    year       = '0;
    #1;
    chk("reset_doy", 32'(doy_g), 32'd0);
    chk("reset_valid", 32'(valid_g), 32'd0);
`ifdef DAYOFYR_LEAP_FLAG_EN
    chk("reset_leap", 32'(leap_g), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    directed(28, 1, 1993, 28);
    directed(11, 6, 1970, 162);
    directed(28, 2, 1971, 59);
    directed(11, 1, 1700, 11);
    directed(27, 11, 1760, 332);
    directed(1, 6, 2016, 153);
    directed(2, 6, 2016, 154);
    directed(8, 4, 1716, 99);
    directed(28, 3, 1960, 88);
    directed(29, 2, 1924, 60);
    directed(20, 2, 980, 51);
    directed(33, 12, 1999, 0);
    directed(8, 14, 1980, 0);
    directed(0, 6, 2000, 0);
    directed(0, 7, 1800, 0);
    directed(0, 8, 2016, 0);
    directed(31, 4, 2001, 0);
    directed(29, 2, 1900, 0);
    chk("jul_feb29_1900", 32'(doy_j), 32'd60);
    chk("jul_feb29_1900_valid", 32'(valid_j), 32'd1);
    directed(1, 3, 1700, 60);
    chk("jul_mar1_1700", 32'(doy_j), 32'd61);
    directed(29, 2, 2000, 60);
    directed(31, 12, 2015, 365);
    directed(1, 1, 0, 1);
    directed(31, 12, 2047, 365);
    directed(5, 0, 2000, 0);
    directed(5, 13, 2000, 0);
    directed(63, 1, 2000, 0);

`ifdef DAYOFYR_LEAP_FLAG_EN
    apply(1, 1, 2000);
    chk("flag_2000", 32'(leap_g), 32'd1);
    apply(1, 1, 1900);
    chk("flag_1900_greg", 32'(leap_g), 32'd0);
    chk("flag_1900_jul", 32'(leap_j), 32'd1);
    apply(0, 5, 2016);
    chk("flag_2016_day0", 32'(leap_g), 32'd1);
`endif

    // Asynchronous reset mid-cycle, then recovery on the next edge.
    directed(31, 12, 2016, 366);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_doy", 32'(doy_g), 32'd0);
    chk("async_rst_valid", 32'(valid_g), 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_doy", 32'(doy_g), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_doy", 32'(doy_g), 32'd366);
    chk("post_rst_valid", 32'(valid_g), 32'd1);

    for (int i = 0; i < 400; i++) begin
      int d, m, y;
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(1, 31));
      m = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 12));
      case ($urandom_range(0, 3))
        0:       y = int'($urandom_range(0, 20)) * 100;
        1:       y = int'($urandom_range(0, 511)) * 4;
        default: y = int'($urandom_range(0, 2047));
      endcase
      if (y > 2047) y = 2000;
      apply(d, m, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
